inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter PC_W, default 16, sets the instruction address width; addresses are word-indexed.
REQ-002 Parameter RST_PC, default 0, is the first fetch address after reset.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 sys_rst  in  1  asynchronous active-low reset.
REQ-006 imem_en  out  1  instruction memory read strobe.
REQ-007 imem_addr  out  PC_W  read address, valid when imem_en=1.
REQ-008 imem_rdata  in  32  instruction word, valid exactly one cycle after imem_en=1.
REQ-009 ir  out  32  instruction word presented to the execute stage (opcode IR[31:27], rdst IR[26:22], rsrc1 IR[21:17], imm_mode IR[16], rsrc2 IR[15:11], isrc IR[15:0]).
REQ-010 ir_pc  out  PC_W  address of the word on ir.
REQ-011 ir_valid  out  1  ir/ir_pc hold a valid word.
REQ-012 ir_ready  in  1  execute stage accepts; a transfer occurs when ir_valid=1 and ir_ready=1.
REQ-013 redirect  in  1  one-cycle pulse that loads a new PC and discards all fetched words.
REQ-014 redirect_pc  in  PC_W  target address, sampled when redirect=1.
REQ-015 halt  in  1  level: while 1, no new fetches are issued.

Function
REQ-016 Words SHALL be buffered in a 2-entry FIFO of {word, pc}; ir/ir_pc SHALL show the FIFO head.
REQ-017 A fetch SHALL be issued (imem_en=1, imem_addr=PC, then PC<=PC+1) only in RUN, with halt=0, redirect=0, and (occupancy + in_flight - pop) < 2, where pop = ir_valid & ir_ready.
REQ-018 With ir_ready held at 1, throughput SHALL be one word per cycle after the first word.
REQ-019 Latency from imem_en to ir_valid SHALL be 2 cycles: data is captured at the end of the return cycle and visible the next cycle.
REQ-020 PC increment SHALL wrap from 2^PC_W-1 to 0 without a flag.
REQ-021 Simultaneous push and pop SHALL keep the occupancy unchanged and preserve order.
REQ-022 No word SHALL be dropped or duplicated under any pattern of ir_ready.
REQ-023 When redirect=1, that cycle's transfer (if any) SHALL complete.
REQ-024 Also in the redirect cycle: FIFO flushed at cycle end; any in-flight response marked discard; PC<=redirect_pc; imem_en=0.
REQ-025 The first fetch after a redirect SHALL issue in the following cycle at redirect_pc.
REQ-026 A discarded response SHALL never reach the FIFO, including when it returns in the cycle right after the redirect.
REQ-027 redirect together with halt=1 SHALL update PC and flush; no fetch is issued until halt=0.
REQ-028 FSM states:
  - RESET_WAIT: one cycle after reset release, then RUN.
  - RUN: issuing; halt=1 moves to HALTED.
  - HALTED: no issue; in-flight word still captured and FIFO still drains; halt=0 moves to RUN, fetching resumes at the held PC the same cycle.

Reset
REQ-029 While sys_rst=0, the block SHALL force: imem_en=0, imem_addr=RST_PC, ir=0, ir_pc=0, ir_valid=0, FIFO empty, in_flight=0, discard=0, PC=RST_PC, state=RESET_WAIT.
REQ-030 Reset asserted mid-operation SHALL abandon the outstanding read; its late imem_rdata SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold:
  - IR field position constants;
  - opcode constants movsgpr=0, mov=1, add=2, sub=3, mul=4;
  - the FSM state type;
  - the FIFO depth constant (2).
REQ-032 The FIFO SHALL be the sub-module ir_fifo (2-entry, width 32+PC_W, push/pop/flush, occupancy output); fetch control, PC and FSM stay in inst_fetch.

Verification
REQ-033 Reset: sys_rst=0 for 3 cycles -> all outputs at their reset values; first imem_en=1 with addr 0 occurs 2 cycles after release.
REQ-034 Stream: imem[0..3]=0x10840004,0x10885000,0x09000037,0x20840004, ir_ready=1 -> those words appear on consecutive cycles with ir_pc 0..3.
REQ-035 Backpressure: ir_ready=0 for 5 cycles mid-stream -> at most 2 words outstanding, imem_en low, ir held stable; on release, order is intact with no gaps.
REQ-036 Redirect: pulse with redirect_pc=0x0040 while one read is in flight and FIFO holds 1 word -> both discarded; next ir_valid word has ir_pc=0x0040.
REQ-037 Halt/wrap: PC=0xFFFF, one fetch, then halt=1 -> the 0xFFFF word delivered and no further imem_en; halt=0 -> next fetch at address 0x0000.
REQ-038 Mid-run reset: reset asserted with a read in flight -> ir_valid=0 immediately; after release fetching restarts at RST_PC with no stale word.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: IR field layout, opcodes,
// fetch FSM states and IR buffer sizing.
package inst_fetch_pkg;

  localparam int unsigned IR_W       = 32;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  // IR field positions
  localparam int unsigned OPCODE_LSB   = 27;
  localparam int unsigned OPCODE_W     = 5;
  localparam int unsigned RDST_LSB     = 22;
  localparam int unsigned RSRC1_LSB    = 17;
  localparam int unsigned IMM_MODE_BIT = 16;
  localparam int unsigned RSRC2_LSB    = 11;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned ISRC_LSB     = 0;
  localparam int unsigned ISRC_W       = 16;

  typedef enum logic [4:0] {
    OP_MOVSGPR = 5'd0,
    OP_MOV     = 5'd1,
    OP_ADD     = 5'd2,
    OP_SUB     = 5'd3,
    OP_MUL     = 5'd4
  } opcode_e;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    RUN        = 2'd1,
    HALTED     = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rdst;
    logic [REG_W-1:0]    rsrc1;
    logic                imm_mode;
    logic [REG_W-1:0]    rsrc2;
    logic [ISRC_W-1:0]   isrc;
  } ir_fields_t;

  // Split an instruction word into its named fields (rsrc2 overlaps isrc).
  function automatic ir_fields_t decode_ir(input logic [IR_W-1:0] w);
    ir_fields_t f;
    f.opcode   = w[OPCODE_LSB +: OPCODE_W];
    f.rdst     = w[RDST_LSB +: REG_W];
    f.rsrc1    = w[RSRC1_LSB +: REG_W];
    f.imm_mode = w[IMM_MODE_BIT];
    f.rsrc2    = w[RSRC2_LSB +: REG_W];
    f.isrc     = w[ISRC_LSB +: ISRC_W];
    return f;
  endfunction

endpackage

// File: rtl/inst_fetch_ir_fifo.sv
// Two-entry shift buffer of fetched {word, pc}; slot 0 is the head driven to execute.
module ir_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic [W-1:0]     tail;
  logic [W-1:0]     head_d;
  logic [W-1:0]     tail_d;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  // Pop shifts tail forward first, so a same-cycle push lands behind any survivor.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
    head_d  = head;
    tail_d  = tail;
    count_d = count;
    if (flush) begin
      count_d = '0;
    end else begin
      if (do_pop) begin
        head_d  = tail;
        count_d = count - CNT_W'(1);
      end
      if (do_push) begin
        if (count_d == '0) head_d = din;
        else               tail_d = din;
        count_d = count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      head  <= head_d;
      tail  <= tail_d;
      count <= count_d;
      valid <= (count_d != '0);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word reads to a one-cycle memory, buffers
// returns in a 2-entry IR buffer and presents them to execute with valid/ready.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned    PC_W   = 16,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            sys_rst,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic [PC_W-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt
);

  localparam int unsigned ENT_W = IR_W + PC_W;
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_e     state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  req_pc;
  logic             in_flight;
  logic             discard;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head;
  logic             pop_c;
  logic             land_c;
  logic             room_c;
  logic             issue_c;
  logic [OCC_W-1:0] occ_c;

  // Issue only if the buffer can absorb everything already owed to it.
  always_comb begin
    pop_c   = ir_valid & ir_ready;
    land_c  = in_flight & ~discard & ~redirect;
    occ_c   = OCC_W'(count) + OCC_W'(in_flight & ~discard) - OCC_W'(pop_c);
    room_c  = (occ_c < OCC_W'(FIFO_DEPTH));
    issue_c = (state != RESET_WAIT) & ~halt & ~redirect & room_c;
  end

  assign imem_en   = issue_c;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= RESET_WAIT;
    end else begin
      case (state)
        RESET_WAIT: state <= RUN;
        RUN:        if (halt) state <= HALTED;
        HALTED:     if (!halt) state <= RUN;
        default:    state <= RESET_WAIT;
      endcase
    end
  end

  // Responses landing in or just after a redirect belong to the old stream.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pc        <= RST_PC;
      req_pc    <= RST_PC;
      in_flight <= 1'b0;
      discard   <= 1'b0;
    end else begin
      in_flight <= issue_c;
      discard   <= redirect;
      if (issue_c) req_pc <= pc;
      if (redirect)     pc <= redirect_pc;
      else if (issue_c) pc <= pc + PC_W'(1);
    end
  end

  ir_fifo #(
    .W(ENT_W)
  ) u_ir_fifo (
    .clk  (clk),
    .rst_n(sys_rst),
    .push (land_c),
    .pop  (pop_c),
    .flush(redirect),
    .din  ({imem_rdata, req_pc}),
    .head (head),
    .valid(ir_valid),
    .count(count)
  );

  assign ir    = head[ENT_W-1:PC_W];
  assign ir_pc = head[PC_W-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle memory model and an
// expected-word scoreboard fed by the bench's own PC sequence.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;

  typedef struct packed {
    logic [31:0] w;
    logic [15:0] pc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] exp_pc;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic        seen;

  always #5 clk = ~clk;

  inst_fetch #(.PC_W(16), .RST_PC(16'h0000)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt)
  );

  function automatic logic [31:0] word_of(input logic [15:0] a);
    case (a)
      16'd0:   return 32'h1084_0004;
      16'd1:   return 32'h1088_5000;
      16'd2:   return 32'h0900_0037;
      16'd3:   return 32'h2084_0004;
      default: return {8'hC3, 8'h5A, a};
    endcase
  endfunction

  // One-cycle instruction memory; keeps answering regardless of reset.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= word_of(imem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: pop on transfer, push on fetch, drop everything owed on redirect.
  task automatic model();
    exp_t e;
    if (ir_valid && ir_ready) begin
      chk("sb_word_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_word", 64'(ir), 64'(e.w));
        chk("sb_pc", 64'(ir_pc), 64'(e.pc));
      end
    end
    if (imem_en) begin
      chk("fetch_addr", 64'(imem_addr), 64'(exp_pc));
      q.push_back({word_of(exp_pc), exp_pc});
      exp_pc = exp_pc + 16'd1;
    end
    if (redirect) begin
      q.delete();
      exp_pc = redirect_pc;
    end
  endtask

  task automatic step();
    model();
    @(negedge clk);
    #1;
  endtask

  initial begin
    sys_rst     = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    exp_pc      = 16'h0000;
    seen        = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_en", 64'(imem_en), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'h0);
    chk("rst_ir", 64'(ir), 64'h0);
    chk("rst_ir_pc", 64'(ir_pc), 64'h0);
    chk("rst_ir_valid", 64'(ir_valid), 64'd0);

    sys_rst  = 1'b1;
    ir_ready = 1'b1;
    #1;
    chk("rst_wait_no_fetch", 64'(imem_en), 64'd0);
    step();
    chk("first_fetch_en", 64'(imem_en), 64'd1);
    chk("first_fetch_addr", 64'(imem_addr), 64'h0);
    step();
    chk("latency_not_yet", 64'(ir_valid), 64'd0);
    step();

    // Back-to-back stream
    for (int k = 0; k < 4; k++) begin
      chk("stream_valid", 64'(ir_valid), 64'd1);
      chk("stream_pc", 64'(ir_pc), 64'(k));
      chk("stream_word", 64'(ir), 64'(word_of(16'(k))));
      step();
    end

    // Backpressure for 5 cycles
    ir_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_no_fetch", 64'(imem_en), 64'd0);
      chk("bp_valid", 64'(ir_valid), 64'd1);
      chk("bp_pc_stable", 64'(ir_pc), 64'd4);
      chk("bp_word_stable", 64'(ir), 64'(word_of(16'd4)));
      step();
    end
    ir_ready = 1'b1;
    #1;
    for (int k = 4; k < 8; k++) begin
      chk("bp_release_valid", 64'(ir_valid), 64'd1);
      chk("bp_release_pc", 64'(ir_pc), 64'(k));
      step();
    end

    // Redirect with one word buffered and one read in flight
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    chk("redir_no_fetch", 64'(imem_en), 64'd0);
    chk("redir_xfer_pc", 64'(ir_pc), 64'd8);
    step();
    redirect = 1'b0;
    #1;
    chk("redir_flushed", 64'(ir_valid), 64'd0);
    chk("redir_fetch_en", 64'(imem_en), 64'd1);
    chk("redir_fetch_addr", 64'(imem_addr), 64'h0040);
    step();
    chk("redir_stale_dropped", 64'(ir_valid), 64'd0);
    step();
    chk("redir_new_valid", 64'(ir_valid), 64'd1);
    chk("redir_new_pc", 64'(ir_pc), 64'h0040);
    chk("redir_new_word", 64'(ir), 64'(word_of(16'h0040)));
    step();
    step();

    // Fetch at 0xFFFF then halt
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    #1;
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_fetch_en", 64'(imem_en), 64'd1);
    chk("wrap_fetch_addr", 64'(imem_addr), 64'hFFFF);
    step();
    halt = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("halt_no_fetch", 64'(imem_en), 64'd0);
      if (ir_valid && ir_pc == 16'hFFFF) seen = 1'b1;
      step();
    end
    chk("halt_word_delivered", 64'(seen), 64'd1);
    chk("halt_drained", 64'(q.size()), 64'd0);
    halt = 1'b0;
    #1;
    chk("resume_fetch_en", 64'(imem_en), 64'd1);
    chk("resume_wrap_addr", 64'(imem_addr), 64'h0000);
    repeat (4) step();

    // Redirect while halted
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    #1;
    chk("rh_no_fetch", 64'(imem_en), 64'd0);
    step();
    redirect = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rh_still_halted", 64'(imem_en), 64'd0);
      chk("rh_flushed", 64'(ir_valid), 64'd0);
      step();
    end
    halt = 1'b0;
    #1;
    chk("rh_resume_en", 64'(imem_en), 64'd1);
    chk("rh_resume_addr", 64'(imem_addr), 64'h0100);
    repeat (4) step();

    // Reset mid-stream with a read in flight
    sys_rst = 1'b0;
    #1;
    chk("mr_valid", 64'(ir_valid), 64'd0);
    chk("mr_no_fetch", 64'(imem_en), 64'd0);
    chk("mr_ir", 64'(ir), 64'h0);
    chk("mr_addr", 64'(imem_addr), 64'h0);
    q.delete();
    exp_pc = 16'h0000;
    repeat (2) step();
    sys_rst = 1'b1;
    #1;
    chk("mr_wait_no_fetch", 64'(imem_en), 64'd0);
    step();
    chk("mr_fetch_en", 64'(imem_en), 64'd1);
    chk("mr_fetch_addr", 64'(imem_addr), 64'h0);
    step();
    chk("mr_no_stale", 64'(ir_valid), 64'd0);
    step();
    chk("mr_first_valid", 64'(ir_valid), 64'd1);
    chk("mr_first_pc", 64'(ir_pc), 64'h0);
    chk("mr_first_word", 64'(ir), 64'(word_of(16'h0)));
    repeat (3) step();

    // Drain: every fetched word must come out
    halt = 1'b1;
    #1;
    repeat (4) step();
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
